// File: rtl/mbist_march_ctrl_if.sv
// Memory-side bundle of the MBIST sequencer: pattern decoder code/data
// plus RAM address, strobes and read data.
interface mbist_march_ctrl_if #(
  parameter int wlength = 4,
  parameter int awidth  = 4
);
  logic [3:0]         pat_code;
  logic [wlength-1:0] pat_data;
  logic [wlength-1:0] mem_rdata;
  logic [awidth-1:0]  mem_addr;
  logic               mem_we;
  logic               mem_re;

  modport master (
    output pat_code, mem_addr, mem_we, mem_re,
    input  pat_data, mem_rdata
  );

  modport slave (
    input  pat_code, mem_addr, mem_we, mem_re,
    output pat_data, mem_rdata
  );
endinterface

// File: rtl/mbist_march_ctrl.sv
// March C- sequencer: three backgrounds, one op per cycle, 2-stage command
// delay to align with the decoder, first-fail capture of addr/bg/element.
module mbist_march_ctrl #(
  parameter int wlength = 4,
  parameter int awidth  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  mbist_march_ctrl_if.master bus,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [awidth-1:0]  fail_addr,
  output logic [1:0]         fail_bg,
  output logic [2:0]         fail_elem
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic              vld;
    logic              we;
    logic [awidth-1:0] addr;
    logic [1:0]        bg;
    logic [2:0]        elem;
  } tag_t;

  localparam logic [awidth-1:0] AMAX = '1;

  state_t st_q, st_d;
  logic [1:0] dc_q, dc_d;
  logic [1:0] bg_q, bg_d, bg_c;
  logic [2:0] el_q, el_d, el_n;
  logic ph_q, ph_d;
  logic [awidth-1:0] ad_q, ad_d;
  logic [3:0] code_q, code_d;
  tag_t t0_q, t0_d, t1_q, t2_q, t3_q;
  logic [wlength-1:0] exp_q;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic pass_q, pass_d;
  logic [awidth-1:0] fa_q, fa_d;
  logic [1:0] fb_q, fb_d;
  logic [2:0] fe_q, fe_d;
  logic go, iss, two_op, we, inv, up, last_a, miss;

  always_comb begin
    st_d   = st_q;
    dc_d   = dc_q;
    el_d   = el_q;
    ph_d   = ph_q;
    ad_d   = ad_q;
    code_d = '0;
    t0_d   = '0;
    pass_d = pass_q;
    fa_d   = fa_q;
    fb_d   = fb_q;
    fe_d   = fe_q;
    go     = start && (st_q == IDLE || st_q == DONE);
    iss    = go || (st_q == RUN && bg_q != 2'd3);
    bg_c   = go ? 2'd0 : bg_q;
    bg_d   = bg_c;
    two_op = el_q != 3'd0 && el_q != 3'd5;
    we     = el_q == 3'd0 || (two_op && ph_q);
    inv    = we ? el_q[0] : ~el_q[0];
    up     = el_q < 3'd3;
    last_a = up ? (ad_q == AMAX) : (ad_q == '0);
    el_n   = (el_q == 3'd5) ? 3'd0 : el_q + 3'd1;
    miss   = t3_q.vld && !t3_q.we && (bus.mem_rdata != exp_q);

    unique case (st_q)
      IDLE, DONE: if (go) st_d = RUN;
      RUN: if (!iss) begin
        st_d = DRAIN;
        dc_d = '0;
      end
      DRAIN: begin
        dc_d = dc_q + 2'd1;
        if (dc_q == 2'd3) st_d = DONE;
      end
    endcase

    if (iss) begin
      code_d    = {1'b1, bg_c, inv};
      t0_d.vld  = 1'b1;
      t0_d.we   = we;
      t0_d.addr = ad_q;
      t0_d.bg   = bg_c;
      t0_d.elem = el_q;
      if (two_op && !ph_q) begin
        ph_d = 1'b1;
      end else begin
        ph_d = 1'b0;
        if (!last_a) begin
          ad_d = up ? ad_q + 1'b1 : ad_q - 1'b1;
        end else begin
          // bg 3 marks all three backgrounds issued
          el_d = el_n;
          ad_d = (el_n < 3'd3) ? '0 : AMAX;
          if (el_q == 3'd5) bg_d = bg_c + 2'd1;
        end
      end
    end

    if (go) begin
      pass_d = 1'b1;
      fa_d   = '0;
      fb_d   = '0;
      fe_d   = '0;
    end else if (miss && pass_q) begin
      pass_d = 1'b0;
      fa_d   = t3_q.addr;
      fb_d   = t3_q.bg;
      fe_d   = t3_q.elem;
    end

    busy_d = st_d == RUN || st_d == DRAIN;
    done_d = st_d == DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      dc_q   <= '0;
      bg_q   <= '0;
      el_q   <= '0;
      ph_q   <= 1'b0;
      ad_q   <= '0;
      code_q <= '0;
      t0_q   <= '0;
      t1_q   <= '0;
      t2_q   <= '0;
      t3_q   <= '0;
      exp_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b1;
      fa_q   <= '0;
      fb_q   <= '0;
      fe_q   <= '0;
    end else begin
      st_q   <= st_d;
      dc_q   <= dc_d;
      bg_q   <= bg_d;
      el_q   <= el_d;
      ph_q   <= ph_d;
      ad_q   <= ad_d;
      code_q <= code_d;
      t0_q   <= t0_d;
      t1_q   <= t0_q;
      t2_q   <= t1_q;
      t3_q   <= t2_q;
      exp_q  <= bus.pat_data;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
      fa_q   <= fa_d;
      fb_q   <= fb_d;
      fe_q   <= fe_d;
    end
  end

  assign bus.pat_code = code_q;
  assign bus.mem_addr = t2_q.addr;
  assign bus.mem_we   = t2_q.vld & t2_q.we;
  assign bus.mem_re   = t2_q.vld & ~t2_q.we;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign fail_addr    = fa_q;
  assign fail_bg      = fb_q;
  assign fail_elem    = fe_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: decoder + faulty RAM models, March C-
// reference walk, table-driven runs, random stuck-at faults, reset abort.
module tb_mbist_march_ctrl;
  localparam int WL = 4;
  localparam int AW = 4;
  localparam int N  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, pass;
  logic [AW-1:0] fail_addr;
  logic [1:0] fail_bg;
  logic [2:0] fail_elem;

  mbist_march_ctrl_if #(.wlength(WL), .awidth(AW)) bus ();

  mbist_march_ctrl #(.wlength(WL), .awidth(AW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .bus(bus.master),
    .busy(busy),
    .done(done),
    .pass(pass),
    .fail_addr(fail_addr),
    .fail_bg(fail_bg),
    .fail_elem(fail_elem)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // fault: 0 none, 1 stuck bit, 2 bits [1:0] wired-OR
  int f_kind = 0, f_addr = 0, f_bit = 0;
  bit f_val = 1'b0;

  function automatic logic [WL-1:0] fapply(input int a, input logic [WL-1:0] w);
    logic [WL-1:0] r;
    r = w;
    if (f_kind == 1 && a == f_addr) r[f_bit] = f_val;
    if (f_kind == 2 && a == f_addr) begin
      r[0] = w[0] | w[1];
      r[1] = w[0] | w[1];
    end
    return r;
  endfunction

  function automatic logic [WL-1:0] patw(input int bg, input bit inv);
    logic [WL-1:0] b;
    b = (bg == 0) ? {WL/4{4'b0000}} : (bg == 1) ? {WL/4{4'b0101}} : {WL/4{4'b0011}};
    return inv ? ~b : b;
  endfunction

  logic [WL-1:0] dec1;
  logic [WL-1:0] ram [N];
  always @(posedge clk) begin
    dec1 <= patw(int'(bus.pat_code[2:1]), bus.pat_code[0]);
    bus.pat_data <= dec1;
    if (bus.mem_we) ram[bus.mem_addr] <= fapply(int'(bus.mem_addr), bus.pat_data);
    if (bus.mem_re) bus.mem_rdata <= fapply(int'(bus.mem_addr), ram[bus.mem_addr]);
  end

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [WL-1:0] d;
  } op_t;

  op_t expq[$];
  bit  m_pass;
  int  m_fa, m_fb, m_fe;

  // March C- walked directly over an array holding the same fault
  task automatic build_model();
    logic [WL-1:0] mm [N];
    op_t o;
    int a;
    bit ri, wi;
    expq.delete();
    m_pass = 1'b1;
    m_fa = 0;
    m_fb = 0;
    m_fe = 0;
    for (int i = 0; i < N; i++) mm[i] = '0;
    for (int bg = 0; bg < 3; bg++)
      for (int e = 0; e < 6; e++)
        for (int k = 0; k < N; k++) begin
          a = (e < 3) ? k : N - 1 - k;
          if (e > 0) begin
            ri = (e == 2 || e == 4);
            o.we = 1'b0;
            o.addr = a[AW-1:0];
            o.d = patw(bg, ri);
            expq.push_back(o);
            if (m_pass && fapply(a, mm[a]) != patw(bg, ri)) begin
              m_pass = 1'b0;
              m_fa = a;
              m_fb = bg;
              m_fe = e;
            end
          end
          if (e < 5) begin
            wi = (e == 1 || e == 3);
            o.we = 1'b1;
            o.addr = a[AW-1:0];
            o.d = patw(bg, wi);
            expq.push_back(o);
            mm[a] = fapply(a, patw(bg, wi));
          end
        end
  endtask

  bit mon_on = 1'b0;
  int op_err = 0;
  int op_cnt = 0;
  string first_dev = "";

  always @(negedge clk) begin
    op_t o;
    if (mon_on && (bus.mem_we || bus.mem_re)) begin
      op_cnt++;
      if (bus.mem_we && bus.mem_re) begin
        op_err++;
      end else if (expq.size() == 0) begin
        op_err++;
      end else begin
        o = expq.pop_front();
        if (o.we != bus.mem_we || o.addr != bus.mem_addr || o.d != bus.pat_data) begin
          if (op_err == 0)
            first_dev = $sformatf("op %0d we=%0b addr=%0h data=%0h, want we=%0b addr=%0h data=%0h",
              op_cnt - 1, bus.mem_we, bus.mem_addr, bus.pat_data, o.we, o.addr, o.d);
          op_err++;
        end
      end
    end
  end

  task automatic check_reset(input string p);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_pass"}, pass, 1);
    chk({p, "_faddr"}, fail_addr, 0);
    chk({p, "_fbg"}, fail_bg, 0);
    chk({p, "_felem"}, fail_elem, 0);
    chk({p, "_strobes"}, {bus.mem_we, bus.mem_re}, 0);
    chk({p, "_code"}, bus.pat_code, 0);
    chk({p, "_addr"}, bus.mem_addr, 0);
  endtask

  task automatic run(input string nm, input bit probe, input bit spam,
                     input bit e_pass, input int e_fa, input int e_fb, input int e_fe);
    int t0, rel, dcyc, first_we;
    op_err = 0;
    op_cnt = 0;
    first_dev = "";
    mon_on = 1'b1;
    @(posedge clk);
    #1 start = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    dcyc = -1;
    first_we = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rel = cyc - t0;
      if (first_we < 0 && bus.mem_we) first_we = rel;
      if (rel == 1) begin
        chk({nm, "_c1_busy"}, busy, 1);
        chk({nm, "_c1_done"}, done, 0);
        chk({nm, "_c1_pass"}, pass, 1);
        chk({nm, "_c1_fail"}, {fail_addr, fail_bg, fail_elem}, 0);
      end
      if (probe) begin
        if (rel >= 1 && rel <= 3) chk($sformatf("%s_code_c%0d", nm, rel), bus.pat_code, 4'b1000);
        if (rel == 17) chk({nm, "_m1_r0_code"}, bus.pat_code, 4'b1000);
        if (rel == 18) chk({nm, "_m1_w1_code"}, bus.pat_code, 4'b1001);
        if (rel == 340) chk({nm, "_bg2_w1"}, {bus.mem_we, bus.mem_addr, bus.pat_data}, {1'b1, 4'h0, 4'b1100});
      end
      if (done) begin
        dcyc = rel;
        break;
      end
      start = spam && (rel % 5 == 2);
    end
    start = 1'b0;
    chk({nm, "_done_cyc"}, dcyc, 30 * N + 5);
    chk({nm, "_busy_at_done"}, busy, 0);
    chk({nm, "_first_we"}, first_we, 3);
    chk({nm, "_pass"}, pass, e_pass);
    chk({nm, "_fail_addr"}, fail_addr, e_fa);
    chk({nm, "_fail_bg"}, fail_bg, e_fb);
    chk({nm, "_fail_elem"}, fail_elem, e_fe);
    chk({nm, "_op_cnt"}, op_cnt, 30 * N);
    chk({nm, "_op_err"}, op_err, 0);
    if (op_err != 0) $display("  %s first deviation: %s", nm, first_dev);
    @(negedge clk);
    mon_on = 1'b0;
  endtask

  typedef struct {
    string nm;
    int kind; int fa; int fbit; bit fval;
    bit probe; bit spam;
    bit e_pass; int e_fa; int e_fb; int e_fe;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int t0, strobes, busy_seen;
    tbl[0] = '{"clean",   0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 0};
    tbl[1] = '{"stuck5",  1, 5, 0, 1'b1, 1'b0, 1'b0, 1'b0, 5, 0, 1};
    tbl[2] = '{"short3",  2, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1, 1};
    tbl[3] = '{"spam",    0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int v = 0; v < 4; v++) begin
      f_kind = tbl[v].kind;
      f_addr = tbl[v].fa;
      f_bit  = tbl[v].fbit;
      f_val  = tbl[v].fval;
      build_model();
      run(tbl[v].nm, tbl[v].probe, tbl[v].spam,
          tbl[v].e_pass, tbl[v].e_fa, tbl[v].e_fb, tbl[v].e_fe);
    end

    f_kind = 0;
    @(posedge clk);
    #1 start = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    while (cyc - t0 < 100) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_reset("midrst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    strobes = 0;
    busy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.mem_we || bus.mem_re) strobes++;
      if (busy || done) busy_seen++;
    end
    chk("midrst_no_strobes", strobes, 0);
    chk("midrst_idle", busy_seen, 0);
    build_model();
    run("after_rst", 1'b0, 1'b0, 1'b1, 0, 0, 0);

    for (int r = 0; r < 4; r++) begin
      f_kind = 1;
      f_addr = $urandom_range(0, N - 1);
      f_bit  = $urandom_range(0, WL - 1);
      f_val  = 1'($urandom_range(0, 1));
      build_model();
      run($sformatf("rnd%0d", r), 1'b0, 1'b0, m_pass, m_fa, m_fb, m_fe);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
